counter_timer: RTL and testbench

COUNTER_TIMER -- requirements
Module: counter_timer

---
 rtl/counter_pkg.sv | 21 ++
 rtl/counter_timer_prescaler.sv | 40 ++++
 rtl/counter_timer.sv | 132 +++++++++++++
 tb/tb_counter_timer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the counter/timer block.
//   MODE_* : values seen on the MODE input (2'b11 is handled as free-running)
//   state_e: controller states
//
//   state | meaning
//   IDLE  | stopped, count held, waiting for START
//   RUN   | counting, prescaler active, BUSY high
//   DONE  | one-shot reached terminal, count held until START or LOAD
package counter_pkg;

  localparam logic [1:0] MODE_FREE     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PERIODIC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/counter_timer_prescaler.sv
// Prescaler: produces one TICK every PRESCALE+1 enabled cycles.
//   CLK      : clock, rising edge
//   RESETN   : asynchronous active-low reset
//   CE       : advance enable
//   CLR      : synchronous clear of the phase counter
//   PRESCALE : divide value minus one
//   TICK     : combinational, CE & (phase == PRESCALE)
module prescaler #(
  parameter int PW = 8
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          CE,
  input  logic          CLR,
  input  logic [PW-1:0] PRESCALE,
  output logic          TICK
);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign TICK = CE && (pcnt_q == PRESCALE);

  always_comb begin
    pcnt_d = pcnt_q;
    if (CLR || TICK) begin
      pcnt_d = '0;
    end else if (CE) begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/counter_timer.sv
// Programmable counter/timer with free-running, one-shot and periodic modes.
//   CLK, RESETN : clock and asynchronous active-low reset
//   EN          : gates prescaler advance while running
//   LOAD, D     : synchronous load of the count
//   START, STOP : begin/restart and halt counting
//   MODE, DIR   : mode select and count direction (1 = down)
//   PERIOD      : terminal value (up) or reload value (down)
//   PRESCALE    : one count step per PRESCALE+1 enabled running cycles
//   O           : registered count
//   TICK        : combinational prescaler tick
//   COUT        : registered one-cycle terminal pulse
//   BUSY        : high while running
//
//   state | meaning
//   IDLE  | stopped, count held, waiting for START
//   RUN   | counting on prescaler ticks
//   DONE  | one-shot finished, count held
module counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int PW    = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic [WIDTH-1:0] PERIOD,
  input  logic [PW-1:0]    PRESCALE,
  output logic [WIDTH-1:0] O,
  output logic             TICK,
  output logic             COUT,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             run, ce, clr, tick;
  logic             step, terminal, oneshot, periodic;

  prescaler #(.PW(PW)) u_prescaler (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .CE       (ce),
    .CLR      (clr),
    .PRESCALE (PRESCALE),
    .TICK     (tick)
  );

  assign oneshot  = (MODE == MODE_ONESHOT);
  assign periodic = (MODE == MODE_PERIODIC);

  // Free mode (including the unused 2'b11 code) terminates at the natural wrap point.
  always_comb begin
    if (DIR) begin
      terminal = (cnt_q == '0);
    end else if (oneshot || periodic) begin
      terminal = (cnt_q == PERIOD);
    end else begin
      terminal = &cnt_q;
    end
  end

  // A tick only moves the count when no higher-priority control is present.
  assign step = tick && !LOAD && !STOP && !START;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (LOAD) begin
      if (state_q == DONE) state_d = IDLE;
    end else if (STOP) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (START) begin
      if (state_q != RUN) state_d = RUN;
    end else if (step && terminal && oneshot) begin
      state_d = DONE;
    end
  end

  always_comb begin
    run  = (state_q == RUN);
    ce   = run && EN;
    clr  = LOAD || STOP || START || !run;
    BUSY = run;
  end

  always_comb begin
    cnt_d  = cnt_q;
    cout_d = 1'b0;
    if (LOAD) begin
      cnt_d = D;
    end else if (step) begin
      cout_d = terminal;
      if (terminal && oneshot) begin
        cnt_d = cnt_q;
      end else if (terminal && periodic) begin
        cnt_d = DIR ? PERIOD : '0;
      end else begin
        cnt_d = DIR ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cout_q <= cout_d;
    end
  end

  assign O    = cnt_q;
  assign TICK = tick;
  assign COUT = cout_q;

endmodule

// File: tb/tb_counter_timer.sv
module tb_counter_timer;

  localparam int WIDTH = 4;
  localparam int PW    = 2;
  localparam int MODV  = 1 << WIDTH;

  logic             CLK = 1'b0;
  logic             RESETN;
  logic             EN, LOAD, START, STOP, DIR;
  logic [WIDTH-1:0] D, PERIOD;
  logic [1:0]       MODE;
  logic [PW-1:0]    PRESCALE;
  logic [WIDTH-1:0] O;
  logic             TICK, COUT, BUSY;

  int total  = 0;
  int passed = 0;

  // Reference model: running/done flags, count and prescaler phase as plain integers.
  int m_run, m_done, m_o, m_pc, m_cout;

  counter_timer #(.WIDTH(WIDTH), .PW(PW)) dut (
    .CLK(CLK), .RESETN(RESETN), .EN(EN), .LOAD(LOAD), .D(D),
    .START(START), .STOP(STOP), .MODE(MODE), .DIR(DIR),
    .PERIOD(PERIOD), .PRESCALE(PRESCALE),
    .O(O), .TICK(TICK), .COUT(COUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_o = 0; m_pc = 0; m_cout = 0;
  endtask

  function automatic int model_tick();
    return (m_run != 0 && EN === 1'b1 && m_pc == int'(PRESCALE)) ? 1 : 0;
  endfunction

  task automatic model_step();
    int tk, up, free, term;
    tk = model_tick();
    m_cout = 0;
    if (LOAD) begin
      m_o = int'(D);
      m_pc = 0;
      m_done = 0;
    end else if (STOP) begin
      m_run = 0;
      m_pc = 0;
    end else if (START) begin
      m_run = 1;
      m_done = 0;
      m_pc = 0;
    end else if (tk != 0) begin
      m_pc = 0;
      up   = (DIR == 1'b0);
      free = (MODE == 2'd0 || MODE == 2'd3);
      if (up) term = free ? (m_o == MODV - 1) : (m_o == int'(PERIOD));
      else    term = (m_o == 0);
      m_cout = term;
      if (term && MODE == 2'd1) begin
        m_run = 0;
        m_done = 1;
      end else if (term && MODE == 2'd2) begin
        m_o = up ? 0 : int'(PERIOD);
      end else begin
        m_o = up ? (m_o + 1) % MODV : (m_o + MODV - 1) % MODV;
      end
    end else if (m_run != 0 && EN) begin
      m_pc = (m_pc + 1) % (1 << PW);
    end else if (m_run == 0) begin
      m_pc = 0;
    end
  endtask

  // One clock cycle: check TICK on the applied inputs, clock, then check registered outputs.
  task automatic cyc();
    #1;
    chk("tick", TICK, model_tick());
    @(posedge CLK);
    model_step();
    #1;
    chk("o", O, m_o);
    chk("cout", COUT, m_cout);
    chk("busy", BUSY, m_run);
  endtask

  initial begin
    int ncout, first_c, second_c;
    RESETN = 1'b0; EN = 0; LOAD = 0; START = 0; STOP = 0; DIR = 0;
    D = '0; PERIOD = '0; MODE = 2'd0; PRESCALE = '0;
    model_reset();
    #12;
    chk("rst_o", O, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cout", COUT, 0);
    chk("rst_tick", TICK, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    EN = 1;
    cyc();
    chk("idle_after_rst", BUSY, 0);

    // Free-running up count, one step per cycle
    MODE = 2'd0; DIR = 0; PRESCALE = 0; START = 1;
    cyc();
    START = 0;
    ncout = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("free_seq", O, (i + 1) % 16);
      if (COUT === 1'b1) ncout++;
    end
    chk("free_cout_cnt", ncout, 1);
    chk("free_wrap_cout", COUT, 1);

    // Periodic up, PERIOD=5, PRESCALE=2
    STOP = 1; cyc(); STOP = 0;
    LOAD = 1; D = 0; cyc(); LOAD = 0;
    MODE = 2'd2; PERIOD = 5; PRESCALE = 2; START = 1;
    cyc();
    START = 0;
    first_c = -1; second_c = -1;
    for (int i = 1; i <= 45; i++) begin
      cyc();
      if (COUT === 1'b1) begin
        if (first_c < 0) first_c = i;
        else if (second_c < 0) second_c = i;
      end
    end
    chk("per_first_cout", first_c, 18);
    chk("per_gap", second_c - first_c, 18);

    // One-shot down from 3
    STOP = 1; cyc(); STOP = 0;
    MODE = 2'd1; DIR = 1; PRESCALE = 0;
    LOAD = 1; D = 3; cyc(); LOAD = 0;
    START = 1; cyc(); START = 0;
    ncout = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (COUT === 1'b1) ncout++;
    end
    chk("os_cout_cnt", ncout, 1);
    chk("os_done_busy", BUSY, 0);
    chk("os_hold", O, 0);
    START = 1; cyc(); START = 0;
    chk("os_restart", BUSY, 1);

    // STOP and START together while running
    MODE = 2'd0; DIR = 0; LOAD = 1; D = 2; cyc(); LOAD = 0;
    START = 1; cyc(); START = 0;
    chk("ss_running", BUSY, 1);
    STOP = 1; START = 1; cyc(); STOP = 0; START = 0;
    chk("ss_idle", BUSY, 0);
    cyc();
    chk("ss_tick_low", TICK, 0);

    // LOAD coincident with a tick
    START = 1; cyc(); START = 0;
    cyc();
    LOAD = 1; D = 9;
    #1;
    chk("ld_tick_present", TICK, 1);
    cyc();
    LOAD = 0;
    chk("ld_value", O, 9);
    PRESCALE = 1;
    cyc();
    chk("ld_pc_cleared", O, 9);

    // Randomized operation
    for (int i = 0; i < 400; i++) begin
      LOAD  = ($urandom_range(0, 15) == 0);
      STOP  = ($urandom_range(0, 24) == 0);
      START = ($urandom_range(0, 5) == 0);
      EN    = ($urandom_range(0, 3) != 0);
      D     = WIDTH'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        MODE     = 2'($urandom);
        DIR      = 1'($urandom);
        PERIOD   = WIDTH'($urandom);
        PRESCALE = PW'($urandom);
      end
      cyc();
    end

    // Reset in the middle of a run
    LOAD = 0; STOP = 1; START = 0; cyc(); STOP = 0;
    MODE = 2'd0; DIR = 0; EN = 0;
    LOAD = 1; D = 7; cyc(); LOAD = 0;
    START = 1; cyc(); START = 0;
    EN = 1; PRESCALE = 3;
    cyc();
    chk("mr_pre_busy", BUSY, 1);
    chk("mr_pre_o", O, 7);
    #2;
    RESETN = 1'b0;
    #1;
    model_reset();
    chk("mr_o", O, 0);
    chk("mr_busy", BUSY, 0);
    chk("mr_cout", COUT, 0);
    chk("mr_tick", TICK, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mr_stay_idle", BUSY, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
